// File: rtl/useq_sequencer.sv
// Microcode sequencer sitting in front of a 1-cycle-latency ROM: fetches a microword,
// then executes jumps, calls/returns, counted loops, timed waits and LED loads.
module useq_sequencer #(
    parameter int DEPTH       = 9,
    parameter int WIDTH       = 32,
    parameter int STACK_DEPTH = 4,
    parameter int LED_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             rom_en,
    output logic [DEPTH-1:0] rom_addr,
    input  logic [DEPTH-1:0] rom_daddr,
    input  logic [WIDTH-1:0] rom_dout,
    output logic [LED_W-1:0] led,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       fault_code
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_CALL = 4'd2;
    localparam logic [3:0] OP_RET  = 4'd3;
    localparam logic [3:0] OP_LED  = 4'd4;
    localparam logic [3:0] OP_WAIT = 4'd5;
    localparam logic [3:0] OP_LOOP = 4'd6;
    localparam logic [3:0] OP_SETL = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    typedef enum logic [1:0] {FETCH, DECODE, WAIT, HALT} state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] pc_q, pc_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [15:0]      loop_cnt_q, loop_cnt_d;
    logic [15:0]      delay_cnt_q, delay_cnt_d;
    logic             fault_q, fault_d;
    logic [2:0]       fault_code_q, fault_code_d;
    logic [DEPTH-1:0] stack_q [STACK_DEPTH];

    logic [3:0]       op;
    logic [15:0]      imm;
    logic [DEPTH-1:0] target;
    logic [DEPTH-1:0] pc_inc;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic             push_en;
    logic             err;
    logic [2:0]       err_code;

    assign op       = rom_dout[WIDTH-1 -: 4];
    assign imm      = rom_dout[WIDTH-5 -: 16];
    assign target   = rom_dout[DEPTH-1:0];
    assign pc_inc   = pc_q + DEPTH'(1);
    assign push_idx = IDX_W'(sp_q);
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

    generate
        if (DEPTH < 12) begin : g_spare
            logic unused_spare_bits;
            assign unused_spare_bits = ^rom_dout[11:DEPTH];
        end
    endgenerate

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        led_d        = led_q;
        sp_d         = sp_q;
        loop_cnt_d   = loop_cnt_q;
        delay_cnt_d  = delay_cnt_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        push_en      = 1'b0;
        err          = 1'b0;
        err_code     = 3'd0;

        case (state_q)
            FETCH: if (run) state_d = DECODE;
            DECODE: if (run) begin
                state_d = FETCH;
                if (rom_daddr != pc_q) begin
                    err      = 1'b1;
                    err_code = 3'd1;
                end else begin
                    case (op)
                        OP_NOP: pc_d = pc_inc;
                        OP_JMP: pc_d = target;
                        OP_CALL: begin
                            if (sp_q == SP_W'(STACK_DEPTH)) begin
                                err      = 1'b1;
                                err_code = 3'd2;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + SP_W'(1);
                                pc_d    = target;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                err      = 1'b1;
                                err_code = 3'd3;
                            end else begin
                                sp_d = sp_q - SP_W'(1);
                                pc_d = stack_q[pop_idx];
                            end
                        end
                        OP_LED: begin
                            led_d = imm[LED_W-1:0];
                            pc_d  = pc_inc;
                        end
                        OP_WAIT: begin
                            pc_d = pc_inc;
                            if (imm != '0) begin
                                delay_cnt_d = imm;
                                state_d     = WAIT;
                            end
                        end
                        OP_LOOP: begin
                            if (loop_cnt_q > 16'd1) begin
                                loop_cnt_d = loop_cnt_q - 16'd1;
                                pc_d       = target;
                            end else begin
                                loop_cnt_d = '0;
                                pc_d       = pc_inc;
                            end
                        end
                        OP_SETL: begin
                            loop_cnt_d = imm;
                            pc_d       = pc_inc;
                        end
                        OP_HALT: state_d = HALT;
                        default: begin
                            err      = 1'b1;
                            err_code = 3'd4;
                        end
                    endcase
                end
            end
            // Leaving on the cycle the counter reads 1 makes the stay exactly imm cycles.
            WAIT: if (run) begin
                if (delay_cnt_q <= 16'd1) begin
                    delay_cnt_d = '0;
                    state_d     = FETCH;
                end else begin
                    delay_cnt_d = delay_cnt_q - 16'd1;
                end
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase

        if (err) begin
            state_d = HALT;
            if (!fault_q) begin
                fault_d      = 1'b1;
                fault_code_d = err_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments; the comb block above uses blocking.
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= '0;
            led_q        <= '0;
            sp_q         <= '0;
            loop_cnt_q   <= '0;
            delay_cnt_q  <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            led_q        <= led_d;
            sp_q         <= sp_d;
            loop_cnt_q   <= loop_cnt_d;
            delay_cnt_q  <= delay_cnt_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    // NOTE: the return stack is plain storage with no reset; sp alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) stack_q[push_idx] <= pc_inc;
    end

    assign rom_en     = (state_q == FETCH) && run;
    assign rom_addr   = pc_q;
    assign led        = led_q;
    assign halted     = (state_q == HALT);
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
endmodule

// File: tb/tb_useq_sequencer.sv
// Bench for useq_sequencer: a table of microprograms whose fetch addresses are
// scoreboarded, plus hand-written sequences for address trace, sticky fault and reset.
`timescale 1ns/1ps
module tb_useq_sequencer;
    localparam int DEPTH       = 9;
    localparam int WIDTH       = 32;
    localparam int STACK_DEPTH = 4;
    localparam int LED_W       = 16;
    localparam int MAXW        = 6;
    localparam int MAXF        = 12;
    localparam int NV          = 12;
    localparam int BUDGET      = 400;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             rom_en;
    logic [DEPTH-1:0] rom_addr;
    logic [DEPTH-1:0] rom_daddr = '0;
    logic [WIDTH-1:0] rom_dout = '0;
    logic [LED_W-1:0] led;
    logic             halted;
    logic             fault;
    logic [2:0]       fault_code;

    useq_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH), .LED_W(LED_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_daddr(rom_daddr), .rom_dout(rom_dout), .led(led), .halted(halted),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Registered ROM model; inj corrupts the echoed address.
    logic [31:0] mem [1 << DEPTH];
    logic        inj = 1'b0;
    always @(posedge clk) begin
        if (rom_en) begin
            rom_dout  <= mem[rom_addr];
            rom_daddr <= rom_addr ^ {{(DEPTH-1){1'b0}}, inj};
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Fetch scoreboard: expected addresses queued per program, popped on each rom_en.
    logic [DEPTH-1:0] exp_q[$];
    bit               mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en && rst_n && rom_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra fetch: got addr 0x%0h expected no fetch", rom_addr);
            end else begin
                check("fetch addr", 32'(rom_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    typedef struct packed {
        logic [3:0]                 n_words;
        logic [MAXW-1:0][DEPTH-1:0] addr;
        logic [MAXW-1:0][31:0]      word;
        logic [3:0]                 n_fetch;
        logic [MAXF-1:0][DEPTH-1:0] fetch;
        logic [15:0]                led;
        logic                       fault;
        logic [2:0]                 code;
        logic [7:0]                 led_cyc;
        logic [7:0]                 halt_cyc;
        logic                       inj;
        logic                       pause;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [15:0] imm,
                                        input logic [DEPTH-1:0] tgt);
        return {op, imm, 12'(tgt)};
    endfunction

    task automatic w(input int v, input int a, input logic [31:0] word);
        vecs[v].addr[vecs[v].n_words] = DEPTH'(a);
        vecs[v].word[vecs[v].n_words] = word;
        vecs[v].n_words = vecs[v].n_words + 4'd1;
    endtask

    task automatic f(input int v, input int a);
        vecs[v].fetch[vecs[v].n_fetch] = DEPTH'(a);
        vecs[v].n_fetch = vecs[v].n_fetch + 4'd1;
    endtask

    task automatic e(input int v, input logic [15:0] l, input logic flt, input logic [2:0] code,
                     input int lc, input int hc, input logic ij, input logic ps);
        vecs[v].led      = l;
        vecs[v].fault    = flt;
        vecs[v].code     = code;
        vecs[v].led_cyc  = 8'(lc);
        vecs[v].halt_cyc = 8'(hc);
        vecs[v].inj      = ij;
        vecs[v].pause    = ps;
    endtask

    task automatic load_rom(input vec_t t);
        for (int a = 0; a < (1 << DEPTH); a++) mem[a] = enc(4'd8, 16'd0, '0);
        for (int k = 0; k < int'(t.n_words); k++) mem[t.addr[k]] = t.word[k];
    endtask

    // Leaves rst_n released just after a rising edge, DUT in FETCH at pc 0.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Cycle counts are in edges where run=1, so paused runs must match unpaused ones.
    task automatic run_vec(input int v);
        vec_t t;
        int   act, led_at, halt_at, extra;
        bit   r;
        t = vecs[v];
        act = 0; led_at = 0; halt_at = 0; extra = 0;
        load_rom(t);
        exp_q.delete();
        for (int k = 0; k < int'(t.n_fetch); k++) exp_q.push_back(t.fetch[k]);
        inj = t.inj;
        do_reset();
        mon_en = 1'b1;
        run = t.pause ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < BUDGET && extra < 4; c++) begin
            @(posedge clk);
            r = run;
            #1;
            if (r) act++;
            if (led !== '0 && led_at == 0) led_at = act;
            if (halted === 1'b1 && halt_at == 0) halt_at = act;
            if (halt_at != 0) extra++;
            run = t.pause ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        mon_en = 1'b0;
        check($sformatf("v%0d reached halt", v), 32'(halt_at != 0), 32'd1);
        check($sformatf("v%0d fetches left", v), 32'(exp_q.size()), 32'd0);
        check($sformatf("v%0d led", v), 32'(led), 32'(t.led));
        check($sformatf("v%0d halted", v), 32'(halted), 32'd1);
        check($sformatf("v%0d fault", v), 32'(fault), 32'(t.fault));
        check($sformatf("v%0d fault_code", v), 32'(fault_code), 32'(t.code));
        if (t.led_cyc != 0) check($sformatf("v%0d led cycle", v), 32'(led_at), 32'(t.led_cyc));
        if (t.halt_cyc != 0) check($sformatf("v%0d halt cycle", v), 32'(halt_at), 32'(t.halt_cyc));
    endtask

    initial begin
        logic [DEPTH-1:0] trace [4];
        int               en_seen;

        for (int v = 0; v < NV; v++) vecs[v] = '0;
        // 0: LED then HALT
        w(0, 0, enc(4'd4, 16'h00A5, '0)); w(0, 1, enc(4'd8, 16'd0, '0));
        f(0, 0); f(0, 1); e(0, 16'h00A5, 0, 0, 2, 4, 0, 0);
        // 1/2: WAIT 3 and WAIT 0
        w(1, 0, enc(4'd5, 16'd3, '0)); w(1, 1, enc(4'd4, 16'd1, '0)); w(1, 2, enc(4'd8, 16'd0, '0));
        f(1, 0); f(1, 1); f(1, 2); e(1, 16'd1, 0, 0, 7, 9, 0, 0);
        w(2, 0, enc(4'd5, 16'd0, '0)); w(2, 1, enc(4'd4, 16'd1, '0)); w(2, 2, enc(4'd8, 16'd0, '0));
        f(2, 0); f(2, 1); f(2, 2); e(2, 16'd1, 0, 0, 4, 6, 0, 0);
        // 3/4: counted loop with SETL 3 and SETL 0
        w(3, 0, enc(4'd7, 16'd3, '0)); w(3, 1, enc(4'd4, 16'd5, '0));
        w(3, 2, enc(4'd6, 16'd0, 9'd1)); w(3, 3, enc(4'd8, 16'd0, '0));
        f(3, 0); for (int k = 0; k < 3; k++) begin f(3, 1); f(3, 2); end f(3, 3);
        e(3, 16'd5, 0, 0, 4, 16, 0, 0);
        w(4, 0, enc(4'd7, 16'd0, '0)); w(4, 1, enc(4'd4, 16'd5, '0));
        w(4, 2, enc(4'd6, 16'd0, 9'd1)); w(4, 3, enc(4'd8, 16'd0, '0));
        f(4, 0); f(4, 1); f(4, 2); f(4, 3); e(4, 16'd5, 0, 0, 4, 8, 0, 0);
        // 5: CALL 0x100 from addr 5, RET returns to 6
        w(5, 0, enc(4'd1, 16'd0, 9'd5)); w(5, 5, enc(4'd2, 16'd0, 9'h100));
        w(5, 256, enc(4'd3, 16'd0, '0)); w(5, 6, enc(4'd4, 16'h003C, '0)); w(5, 7, enc(4'd8, 16'd0, '0));
        f(5, 0); f(5, 5); f(5, 256); f(5, 6); f(5, 7); e(5, 16'h003C, 0, 0, 8, 10, 0, 0);
        // 6: five nested CALLs overflow a 4-deep stack
        for (int k = 0; k < 5; k++) begin w(6, k, enc(4'd2, 16'd0, 9'(k + 1))); f(6, k); end
        e(6, 16'd0, 1, 3'd2, 0, 10, 0, 0);
        // 7: RET on empty stack
        w(7, 0, enc(4'd4, 16'd7, '0)); w(7, 1, enc(4'd3, 16'd0, '0));
        f(7, 0); f(7, 1); e(7, 16'd7, 1, 3'd3, 2, 4, 0, 0);
        // 8: illegal opcode 0xF
        w(8, 0, 32'hF000_0000); f(8, 0); e(8, 16'd0, 1, 3'd4, 0, 2, 0, 0);
        // 9: pc wrap 511 -> 0, steered out by the loop counter
        w(9, 0, enc(4'd6, 16'd0, 9'd3)); w(9, 1, enc(4'd7, 16'd2, '0)); w(9, 2, enc(4'd1, 16'd0, 9'd511));
        w(9, 511, enc(4'd0, 16'd0, '0)); w(9, 3, enc(4'd8, 16'd0, '0));
        f(9, 0); f(9, 1); f(9, 2); f(9, 511); f(9, 0); f(9, 3); e(9, 16'd0, 0, 0, 0, 12, 0, 0);
        // 10: echoed address mismatch; the LED must not execute
        w(10, 0, enc(4'd4, 16'h0099, '0)); w(10, 1, enc(4'd8, 16'd0, '0));
        f(10, 0); e(10, 16'd0, 1, 3'd1, 0, 2, 1, 0);
        // 11: WAIT 10 with random run pauses
        w(11, 0, enc(4'd4, 16'd2, '0)); w(11, 1, enc(4'd5, 16'd10, '0));
        w(11, 2, enc(4'd4, 16'h0077, '0)); w(11, 3, enc(4'd8, 16'd0, '0));
        f(11, 0); f(11, 1); f(11, 2); f(11, 3); e(11, 16'h0077, 0, 0, 2, 18, 0, 1);

        #1;
        check("reset led", 32'(led), 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        check("reset fault_code", 32'(fault_code), 32'd0);
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        check("reset rom_en", 32'(rom_en), 32'd0);

        for (int v = 0; v < NV; v++) begin
            run_vec(v);
            if (v == 7) begin
                // A later error source must not disturb the first fault code.
                inj = 1'b1;
                run = 1'b1;
                en_seen = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (rom_en) en_seen++;
                end
                check("sticky rom_en count", 32'(en_seen), 32'd0);
                check("sticky fault_code", 32'(fault_code), 32'd3);
                check("sticky halted", 32'(halted), 32'd1);
            end
        end

        // Address trace of the LED program over the first four cycles.
        inj = 1'b0;
        load_rom(vecs[0]);
        do_reset();
        run = 1'b1;
        trace[0] = 9'd0; trace[1] = 9'd0; trace[2] = 9'd1; trace[3] = 9'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("trace cycle %0d rom_addr", k), 32'(rom_addr), 32'(trace[k]));
        end

        // Reset asserted in the middle of a WAIT.
        load_rom(vecs[11]);
        do_reset();
        run = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mid-wait led before reset", 32'(led), 32'h0002);
        check("mid-wait rom_en in WAIT", 32'(rom_en), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async reset led", 32'(led), 32'd0);
        check("async reset halted", 32'(halted), 32'd0);
        check("async reset fault", 32'(fault), 32'd0);
        check("async reset rom_addr", 32'(rom_addr), 32'd0);
        check("async reset rom_en", 32'(rom_en), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("refetch rom_en", 32'(rom_en), 32'd1);
        check("refetch rom_addr", 32'(rom_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("refetch led", 32'(led), 32'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/useq_sequencer.md
Name: useq_sequencer

Overview:
- Microcode sequencer that sits directly upstream of the microcode ROM.
- Drives the ROM's enable and address, consumes the registered microword and echoed address one cycle later, and executes it.
- Executes jumps, calls/returns, counted loops, timed waits and LED register loads.
- The LED register is the design's visible output.

Parameters:
- DEPTH, 9, ROM address width; must be 12 or less. The PC, stack entries and target field are all DEPTH bits.
- WIDTH, 32, microword width; fixed at 32 for the field map below.
- STACK_DEPTH, 4, return-stack entries, 1 to 8.
- LED_W, 16, LED register width, 16 or less.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 lets the sequencer advance; 0 freezes all state
- rom_en  out  1  ROM read enable
- rom_addr  out  DEPTH  ROM read address; equals pc
- rom_daddr  in  DEPTH  address echoed by the ROM with the data
- rom_dout  in  WIDTH  microword from the ROM
- led  out  LED_W  LED register
- halted  out  1  1 in HALT state
- fault  out  1  sticky error flag
- fault_code  out  3  cause of the first fault

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: state=FETCH, pc=0, led=0, halted=0, fault=0, fault_code=0, sp=0, loop_cnt=0, delay_cnt=0.
- Microword fields (1-based bit numbering):
  - op = [32:29]
  - imm = [28:13], 16 bits
  - target = [DEPTH:1]
- States: FETCH, DECODE, WAIT, HALT.
- FETCH:
  - rom_en = run (combinational from state); rom_addr = pc.
  - If run=1, go to DECODE.
- DECODE:
  - rom_dout is valid here (ROM has 1-cycle latency).
  - If rom_daddr != pc: fault, fault_code=1.
  - Otherwise execute op, then go to FETCH unless the op says otherwise.
- Opcodes:
  - 0 NOP: pc<=pc+1.
  - 1 JMP: pc<=target.
  - 2 CALL:
    - If sp==STACK_DEPTH: fault, code 2.
    - Else stack[sp]<=pc+1, sp<=sp+1, pc<=target.
  - 3 RET:
    - If sp==0: fault, code 3.
    - Else sp<=sp-1, pc<=stack[sp-1].
  - 4 LED: led<=imm[LED_W-1:0]; pc<=pc+1.
  - 5 WAIT:
    - If imm==0: pc<=pc+1, go to FETCH.
    - Else delay_cnt<=imm, pc<=pc+1, go to WAIT.
  - 6 LOOP:
    - If loop_cnt>1: loop_cnt<=loop_cnt-1, pc<=target.
    - Else: loop_cnt<=0, pc<=pc+1.
    - Result: the body executes loop_cnt times; a count of 0 or 1 executes it once.
  - 7 SETL: loop_cnt<=imm; pc<=pc+1.
  - 8 HALT: go to HALT, halted=1; pc unchanged.
  - 9-15: fault, code 4.
- WAIT: delay_cnt decrements each run=1 cycle. Leaving WAIT on the cycle it reads 1 makes the stay exactly imm cycles, then go to FETCH.
- HALT and fault:
  - HALT is terminal until reset; rom_en=0.
  - Any fault also enters HALT with halted=1, fault=1, and fault_code holding the first cause.
  - led keeps its value.
- run=0 behaviour:
  - In FETCH: rom_en=0.
  - In DECODE or WAIT: no state or counter changes; the ROM output stays stable because rom_en was 0.
  - Effect: a pause for any number of cycles is transparent.
  - Deasserting run in DECODE is legal; the instruction executes on the first run=1 cycle.
- Arithmetic and wrap:
  - pc+1 wraps from 2^DEPTH-1 to 0.
  - A CALL at the last address pushes 0.
  - loop_cnt and delay_cnt are 16-bit unsigned and never go below 0.
- Timing: a normal instruction takes 2 cycles (FETCH+DECODE); WAIT imm=N takes 2+N.
- Reset mid-operation: asynchronous return to the reset values; stack contents are don't-care.
- Nesting: loops nest only through CALL; there is a single loop_cnt.

Test Plan:
- Basic LED load: ROM[0]=LED 0x00A5, ROM[1]=HALT, run=1 from reset -> rom_addr 0,0,1,1 over four cycles; led=0x00A5 from cycle 2; halted=1 from cycle 4; fault=0.
- Timed wait: ROM[0]=WAIT 3, ROM[1]=LED 1, ROM[2]=HALT -> led changes exactly 2+3+2=7 cycles after reset release; WAIT 0 variant -> 4 cycles.
- Counted loop: SETL 3, then body LED at addr 1, then LOOP target=1 -> body fetched at addr 1 three times, then pc=3; repeat with SETL 0 -> body once.
- Call/return and overflow: CALL 0x100 at addr 5, RET at 0x100 -> next fetch at addr 6. Five nested CALLs with STACK_DEPTH=4 -> fault=1, fault_code=2, halted=1.
- Error paths: RET with an empty stack -> code 3. Opcode 0xF -> code 4. Forcing rom_daddr != pc in DECODE -> code 1. A later error leaves the first code unchanged.
- Pause and reset: toggle run randomly during a WAIT 10 program -> same instruction sequence and led as run=1, stretched by the paused cycles. Assert rst_n low mid-WAIT -> all outputs return to their reset values immediately; the next fetch is addr 0. Also check pc wrap: JMP to 511 with NOP there -> next fetch is addr 0.
